// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I pipeline control blocks.
package rv32i_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned TMO_W = 8;
    localparam int unsigned CNT_W = 32;

    // Hazard scheduler sequencing states
    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        MEMWAIT = 2'd2
    } hazState_t;

    // Execute-stage operand forward selects
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;

    // ResultSrcE encoding that marks a load in Execute
    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    // True when a load in Execute produces a register the Decode instruction reads
    function automatic logic loadUse(
        input logic [1:0]       resultSrcE,
        input logic [REG_W-1:0] rdE,
        input logic [REG_W-1:0] rs1D,
        input logic [REG_W-1:0] rs2D
    );
        return (resultSrcE == RESULTSRC_LOAD) && (rdE != '0) &&
               ((rdE == rs1D) || (rdE == rs2D));
    endfunction

endpackage

// File: rtl/rv32i_fwd_sel.sv
// Per-operand forward selection for Execute; Memory-stage result has priority.
module rv32i_fwd_sel
    import rv32i_pkg::*;
(
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rdM,
    input  logic [REG_W-1:0] rdW,
    input  logic             regWriteM,
    input  logic             regWriteW,
    output logic [1:0]       forward_c
);

    // x0 is never forwarded; newest producer (M) beats W
    always_comb begin
        forward_c = FWD_NONE;
        if ((rsE != '0) && regWriteM && (rdM == rsE)) begin
            forward_c = FWD_M;
        end else if ((rsE != '0) && regWriteW && (rdW == rsE)) begin
            forward_c = FWD_W;
        end
    end

endmodule

// File: rtl/rv32i_hazard_sched.sv
// Hazard controller for the 5-stage RV32I core: post-reset drain, load-use
// stalls, redirect flushes, data-memory wait handling and Execute forwarding.
module rv32i_hazard_sched
    import rv32i_pkg::*;
#(
    parameter int unsigned INIT_FLUSH = 2,
    parameter int unsigned MEM_TMO    = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic [REG_W-1:0] RdM,
    input  logic [REG_W-1:0] RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             StallEM,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] StallCnt,
    output logic             MemTimeout
);

    localparam int unsigned        INIT_W    = (INIT_FLUSH > 1) ? $clog2(INIT_FLUSH) : 1;
    localparam logic [INIT_W-1:0]  INIT_LOAD = INIT_W'(INIT_FLUSH - 1);
    localparam logic [TMO_W-1:0]   TMO_LIMIT = TMO_W'(MEM_TMO);

    hazState_t         state;
    hazState_t         stateNext;
    logic [INIT_W-1:0] initCnt;
    logic [TMO_W-1:0]  tmoCnt;
    logic              lwStall;

    assign lwStall = loadUse(ResultSrcE, RdE, Rs1D, Rs2D);

    // State register; reset always lands in INIT with nothing pending
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and stall/flush decode
    always_comb begin
        stateNext = state;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        StallEM   = 1'b0;
        FlushW    = 1'b0;
        case (state)
            INIT: begin
                StallF = 1'b1;
                FlushD = 1'b1;
                FlushE = 1'b1;
                if (initCnt == '0) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (MemReqM && !MemReadyM) begin
                    // Wait outputs take effect in the cycle the miss is seen
                    stateNext = MEMWAIT;
                    StallF    = 1'b1;
                    StallD    = 1'b1;
                    StallEM   = 1'b1;
                    FlushW    = 1'b1;
                end else if (PCSrcE) begin
                    // Redirect squashes the younger instructions, including a stalled one
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (lwStall) begin
                    // Bubble into E lets the load advance, so this lasts one cycle
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            MEMWAIT: begin
                // E is frozen here, so a redirect in E is re-seen after the wait
                StallF  = 1'b1;
                StallD  = 1'b1;
                StallEM = 1'b1;
                FlushW  = !MemReadyM;
                if (MemReadyM) begin
                    stateNext = RUN;
                end
            end
            default: begin
                stateNext = INIT;
            end
        endcase
    end

    // Post-reset drain counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            initCnt <= INIT_LOAD;
        end else if ((state == INIT) && (initCnt != '0)) begin
            initCnt <= initCnt - INIT_W'(1);
        end
    end

    // Memory-wait duration counter, cleared outside MEMWAIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmoCnt <= '0;
        end else if (state == MEMWAIT) begin
            if (tmoCnt != '1) begin
                tmoCnt <= tmoCnt + TMO_W'(1);
            end
        end else begin
            tmoCnt <= '0;
        end
    end

    // Sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            MemTimeout <= 1'b0;
        end else if ((state == MEMWAIT) && (tmoCnt == TMO_LIMIT)) begin
            MemTimeout <= 1'b1;
        end
    end

    // Saturating count of fetch-stall cycles outside the reset drain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            StallCnt <= '0;
        end else if ((state != INIT) && StallF && (StallCnt != '1)) begin
            StallCnt <= StallCnt + CNT_W'(1);
        end
    end

    rv32i_fwd_sel u_fwdA (
        .rsE       (Rs1E),
        .rdM       (RdM),
        .rdW       (RdW),
        .regWriteM (RegWriteM),
        .regWriteW (RegWriteW),
        .forward_c (ForwardAE)
    );

    rv32i_fwd_sel u_fwdB (
        .rsE       (Rs2E),
        .rdM       (RdM),
        .rdW       (RdW),
        .regWriteM (RegWriteM),
        .regWriteW (RegWriteW),
        .forward_c (ForwardBE)
    );

endmodule

// File: tb/tb_rv32i_hazard_sched.sv
// Bench for rv32i_hazard_sched: vector table, directed corner sequences and
// random traffic against a cycle-level behavioural model.
module tb_rv32i_hazard_sched;

    localparam int unsigned INIT_FLUSH = 2;
    localparam int unsigned MEM_TMO    = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]  ResultSrcE;
    logic        RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic        StallF, StallD, FlushD, FlushE, StallEM, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] StallCnt;
    logic        MemTimeout;

    always #5 clk = ~clk;

    rv32i_hazard_sched #(.INIT_FLUSH(INIT_FLUSH), .MEM_TMO(MEM_TMO)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .StallEM(StallEM), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallCnt(StallCnt), .MemTimeout(MemTimeout)
    );

    typedef struct packed {
        logic       stallF;
        logic       stallD;
        logic       flushD;
        logic       flushE;
        logic       stallEM;
        logic       flushW;
        logic [1:0] fwdA;
        logic [1:0] fwdB;
    } outs_t;

    typedef struct {
        string      name;
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic [1:0] resSrc;
        logic       regWM, regWW, pcSrc;
        outs_t      exp;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Behavioural model: mode 0 = draining after reset, 1 = running, 2 = waiting on memory
    int          mMode;
    int          mInitLeft;
    int          mWait;
    bit          mTmo;
    logic [31:0] mStall;

    function automatic outs_t mkOut(input bit sf, input bit sd, input bit fd, input bit fe,
                                    input bit sem, input bit fw,
                                    input logic [1:0] fa, input logic [1:0] fb);
        outs_t o;
        o.stallF = sf; o.stallD = sd; o.flushD = fd; o.flushE = fe;
        o.stallEM = sem; o.flushW = fw; o.fwdA = fa; o.fwdB = fb;
        return o;
    endfunction

    function automatic vec_t mkVec(input string n,
                                   input logic [4:0] r1d, input logic [4:0] r2d,
                                   input logic [4:0] r1e, input logic [4:0] r2e,
                                   input logic [4:0] rde, input logic [4:0] rdm, input logic [4:0] rdw,
                                   input logic [1:0] rs, input bit wm, input bit ww, input bit pc,
                                   input outs_t e);
        vec_t v;
        v.name = n; v.rs1D = r1d; v.rs2D = r2d; v.rs1E = r1e; v.rs2E = r2e;
        v.rdE = rde; v.rdM = rdm; v.rdW = rdw; v.resSrc = rs;
        v.regWM = wm; v.regWW = ww; v.pcSrc = pc; v.exp = e;
        return v;
    endfunction

    function automatic logic [1:0] refFwd(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (RegWriteM && RdM == rs) return 2'b10;
        if (RegWriteW && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic outs_t expOuts();
        outs_t o;
        bit    lw;
        o = '0;
        o.fwdA = refFwd(Rs1E);
        o.fwdB = refFwd(Rs2E);
        lw = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
        if (mMode == 0) begin
            o.stallF = 1; o.flushD = 1; o.flushE = 1;
        end else if (mMode == 2 || (MemReqM && !MemReadyM)) begin
            o.stallF = 1; o.stallD = 1; o.stallEM = 1;
            o.flushW = (mMode == 2) ? !MemReadyM : 1'b1;
        end else if (PCSrcE) begin
            o.flushD = 1; o.flushE = 1;
        end else if (lw) begin
            o.stallF = 1; o.stallD = 1; o.flushE = 1;
        end
        return o;
    endfunction

    function automatic void modelReset();
        mMode = 0; mInitLeft = int'(INIT_FLUSH); mWait = 0; mTmo = 0; mStall = '0;
    endfunction

    function automatic void modelStep(input outs_t e);
        if (mMode != 0 && e.stallF && mStall != 32'hFFFF_FFFF) mStall = mStall + 32'd1;
        if (mMode == 0) begin
            mInitLeft--;
            if (mInitLeft == 0) mMode = 1;
        end else if (mMode == 1) begin
            if (MemReqM && !MemReadyM) begin
                mMode = 2;
                mWait = 0;
            end
        end else begin
            mWait++;
            if (mWait > int'(MEM_TMO)) mTmo = 1;
            if (MemReadyM) mMode = 1;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic cmpOuts(input string tag, input outs_t want);
        chk({tag, ".StallF"},    32'(StallF),    32'(want.stallF));
        chk({tag, ".StallD"},    32'(StallD),    32'(want.stallD));
        chk({tag, ".FlushD"},    32'(FlushD),    32'(want.flushD));
        chk({tag, ".FlushE"},    32'(FlushE),    32'(want.flushE));
        chk({tag, ".StallEM"},   32'(StallEM),   32'(want.stallEM));
        chk({tag, ".FlushW"},    32'(FlushW),    32'(want.flushW));
        chk({tag, ".ForwardAE"}, 32'(ForwardAE), 32'(want.fwdA));
        chk({tag, ".ForwardBE"}, 32'(ForwardBE), 32'(want.fwdB));
    endtask

    // One clock: sample at negedge against model (and optional constant), then advance model
    task automatic runCycle(input string tag, input bit useConst, input outs_t want);
        outs_t e;
        @(negedge clk);
        e = expOuts();
        cmpOuts({tag, ".model"}, e);
        chk({tag, ".StallCnt"}, StallCnt, mStall);
        chk({tag, ".MemTimeout"}, 32'(MemTimeout), 32'(mTmo));
        if (useConst) cmpOuts({tag, ".const"}, want);
        @(posedge clk);
        modelStep(e);
        #1;
    endtask

    task automatic clearInputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0; ResultSrcE = '0;
        RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 1;
    endtask

    vec_t  vecs[13];
    outs_t INIT_O, ZERO_O, WAIT_O, WAITR_O, LW_O;

    initial begin
        INIT_O  = mkOut(1, 0, 1, 1, 0, 0, 2'b00, 2'b00);
        ZERO_O  = mkOut(0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        WAIT_O  = mkOut(1, 1, 0, 0, 1, 1, 2'b00, 2'b00);
        WAITR_O = mkOut(1, 1, 0, 0, 1, 0, 2'b00, 2'b00);
        LW_O    = mkOut(1, 1, 0, 1, 0, 0, 2'b00, 2'b00);

        //                 name            r1d r2d r1e r2e rdE rdM rdW src   wm ww pc
        vecs[0]  = mkVec("fwdA_M",        0,  0,  3,  0,  0,  3,  3,  2'b00, 1, 1, 0, mkOut(0,0,0,0,0,0,2'b10,2'b00));
        vecs[1]  = mkVec("fwdA_W",        0,  0,  3,  0,  0,  3,  3,  2'b00, 0, 1, 0, mkOut(0,0,0,0,0,0,2'b01,2'b00));
        vecs[2]  = mkVec("fwdA_x0",       0,  0,  0,  0,  0,  3,  3,  2'b00, 1, 1, 0, mkOut(0,0,0,0,0,0,2'b00,2'b00));
        vecs[3]  = mkVec("fwdB_M",        0,  0,  0,  7,  0,  7,  0,  2'b00, 1, 0, 0, mkOut(0,0,0,0,0,0,2'b00,2'b10));
        vecs[4]  = mkVec("fwdB_W",        0,  0,  0,  9,  0,  9,  9,  2'b00, 0, 1, 0, mkOut(0,0,0,0,0,0,2'b00,2'b01));
        vecs[5]  = mkVec("fwd_both",      0,  0,  4,  6,  0,  4,  6,  2'b00, 1, 1, 0, mkOut(0,0,0,0,0,0,2'b10,2'b01));
        vecs[6]  = mkVec("lw_rs2",        0,  8,  0,  0,  8,  0,  0,  2'b01, 0, 0, 0, mkOut(1,1,0,1,0,0,2'b00,2'b00));
        vecs[7]  = mkVec("lw_x0",         0,  0,  0,  0,  0,  0,  0,  2'b01, 0, 0, 0, mkOut(0,0,0,0,0,0,2'b00,2'b00));
        vecs[8]  = mkVec("lw_redirect",   5,  0,  0,  0,  5,  0,  0,  2'b01, 0, 0, 1, mkOut(0,0,1,1,0,0,2'b00,2'b00));
        vecs[9]  = mkVec("not_load",      5,  0,  0,  0,  5,  0,  0,  2'b10, 0, 0, 0, mkOut(0,0,0,0,0,0,2'b00,2'b00));
        vecs[10] = mkVec("jump",          0,  0,  0,  0,  0,  0,  0,  2'b00, 0, 0, 1, mkOut(0,0,1,1,0,0,2'b00,2'b00));
        vecs[11] = mkVec("fwd_noWrite",   0,  0,  3,  3,  0,  3,  3,  2'b00, 0, 0, 0, mkOut(0,0,0,0,0,0,2'b00,2'b00));
        vecs[12] = mkVec("lw_and_fwd",    2,  0,  2,  0,  2,  2,  0,  2'b01, 1, 0, 0, mkOut(1,1,0,1,0,0,2'b10,2'b00));

        // Reset state and post-reset drain
        clearInputs();
        modelReset();
        @(negedge clk);
        cmpOuts("inReset", INIT_O);
        chk("inReset.StallCnt", StallCnt, 32'd0);
        chk("inReset.MemTimeout", 32'(MemTimeout), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        runCycle("init1", 1, INIT_O);
        runCycle("init2", 1, INIT_O);
        runCycle("run0", 1, ZERO_O);
        chk("afterInit.StallCnt", StallCnt, 32'd0);

        // Load-use on x5: exactly one stall cycle once the load leaves E
        ResultSrcE = 2'b01; RdE = 5'd5; Rs1D = 5'd5;
        runCycle("lw5", 1, LW_O);
        clearInputs();
        runCycle("lw5_next", 1, ZERO_O);
        chk("lw5.StallCnt", StallCnt, 32'd1);

        // Vector table in RUN
        foreach (vecs[i]) begin
            Rs1D = vecs[i].rs1D; Rs2D = vecs[i].rs2D; Rs1E = vecs[i].rs1E; Rs2E = vecs[i].rs2E;
            RdE = vecs[i].rdE; RdM = vecs[i].rdM; RdW = vecs[i].rdW; ResultSrcE = vecs[i].resSrc;
            RegWriteM = vecs[i].regWM; RegWriteW = vecs[i].regWW; PCSrcE = vecs[i].pcSrc;
            MemReqM = 0; MemReadyM = 1;
            runCycle(vecs[i].name, 1, vecs[i].exp);
        end
        clearInputs();

        // Memory wait: ready low 4 cycles, then ready; redirect in E must be ignored meanwhile
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 4; i++) begin
            PCSrcE = (i == 2);
            runCycle("memwait", 1, WAIT_O);
        end
        PCSrcE = 0; MemReadyM = 1;
        runCycle("memready", 1, WAITR_O);
        MemReqM = 0;
        runCycle("memdone", 1, ZERO_O);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
            PCSrcE = ($urandom_range(0, 4) == 0);
            MemReqM = ($urandom_range(0, 3) == 0);
            MemReadyM = ($urandom_range(0, 3) != 0);
            runCycle("rnd", 0, ZERO_O);
        end

        // Timeout: get back to RUN, then hold ready low well past the limit
        clearInputs();
        runCycle("preTmo1", 0, ZERO_O);
        runCycle("preTmo2", 0, ZERO_O);
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 300; i++) begin
            runCycle("tmo", 0, ZERO_O);
            if (i == 100) chk("tmo.early", 32'(MemTimeout), 32'd0);
        end
        chk("tmo.set", 32'(MemTimeout), 32'd1);

        // Reset asserted mid-wait clears everything immediately
        rst = 1'b0;
        clearInputs();
        modelReset();
        @(negedge clk);
        cmpOuts("rstMid", INIT_O);
        chk("rstMid.MemTimeout", 32'(MemTimeout), 32'd0);
        chk("rstMid.StallCnt", StallCnt, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        runCycle("reinit1", 1, INIT_O);
        runCycle("reinit2", 1, INIT_O);
        runCycle("rerun", 1, ZERO_O);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stuck simulation
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
